// File: rtl/phy_tx_serializer_n_if.sv
// Word handshake between the upstream framer and the TX serializer.
// master: drives data_in/valid_in; slave: returns ready_out.
interface phy_tx_serializer_n_if #(
  parameter int LANES = 2,
  parameter int WIDTH = 8
) ();
  logic [LANES*WIDTH-1:0] data_in;
  logic [LANES-1:0]       valid_in;
  logic                   ready_out;

  modport master (
    output data_in,
    output valid_in,
    input  ready_out
  );

  modport slave (
    input  data_in,
    input  valid_in,
    output ready_out
  );
endinterface

// File: rtl/phy_tx_serializer_n.sv
// N-lane parallel-to-serial PHY transmitter on the serial-rate clock.
// Ports: clk_8f, reset (async, active-low), tx (data_in/valid_in/ready_out),
// sync_req, link_up, word_strobe, serial_out (one bit per lane per cycle).
module phy_tx_serializer_n #(
  parameter int               LANES      = 2,
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] IDLE_WORD  = 8'hBC,
  parameter int               SYNC_WORDS = 4,
  parameter int               MSB_FIRST  = 1
) (
  input  logic                 clk_8f,
  input  logic                 reset,
  phy_tx_serializer_n_if.slave tx,
  input  logic                 sync_req,
  output logic                 link_up,
  output logic                 word_strobe,
  output logic [LANES-1:0]     serial_out
);

  localparam int CW  = $clog2(WIDTH);
  localparam int SCW = (SYNC_WORDS > 1) ? $clog2(SYNC_WORDS) : 1;
  localparam logic [CW-1:0]  CNT_LAST  = CW'(WIDTH - 1);
  localparam logic [SCW-1:0] SYNC_LAST = SCW'(SYNC_WORDS - 1);

  typedef enum logic {
    SYNC,
    ACTIVE
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [SCW-1:0]   sync_cnt;
  logic [WIDTH-1:0] sr [LANES];
  logic             ready;

  assign word_strobe  = (cnt == CNT_LAST);
  assign ready        = link_up & word_strobe & ~sync_req;
  assign tx.ready_out = ready;

  always_comb begin
    serial_out = '0;
    for (int i = 0; i < LANES; i++) begin
      serial_out[i] = (MSB_FIRST != 0) ? sr[i][WIDTH-1] : sr[i][0];
    end
  end

  always_ff @(posedge clk_8f or negedge reset) begin
    if (!reset) begin
      state    <= SYNC;
      cnt      <= '0;
      sync_cnt <= '0;
      link_up  <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        sr[i] <= IDLE_WORD;
      end
    end else if (word_strobe) begin
      cnt <= '0;
      // ready is low whenever a retrain is requested, so idle is loaded then
      for (int i = 0; i < LANES; i++) begin
        if (ready && tx.valid_in[i]) begin
          sr[i] <= tx.data_in[i*WIDTH +: WIDTH];
        end else begin
          sr[i] <= IDLE_WORD;
        end
      end
      unique case (state)
        SYNC: begin
          if (sync_req) begin
            sync_cnt <= '0;
          end else if (sync_cnt == SYNC_LAST) begin
            state   <= ACTIVE;
            link_up <= 1'b1;
          end else begin
            sync_cnt <= sync_cnt + 1'b1;
          end
        end
        ACTIVE: begin
          if (sync_req) begin
            state    <= SYNC;
            sync_cnt <= '0;
            link_up  <= 1'b0;
          end
        end
        default: begin
          state <= SYNC;
        end
      endcase
    end else begin
      cnt <= cnt + 1'b1;
      for (int i = 0; i < LANES; i++) begin
        if (MSB_FIRST != 0) begin
          sr[i] <= {sr[i][WIDTH-2:0], 1'b0};
        end else begin
          sr[i] <= {1'b0, sr[i][WIDTH-1:1]};
        end
      end
    end
  end

endmodule

// File: tb/tb_phy_tx_serializer_n.sv
// Testbench for phy_tx_serializer_n: MSB-first and LSB-first instances
// share stimulus; a word-level model and directed tables check both.
module tb_phy_tx_serializer_n;

  localparam int         L    = 2;
  localparam int         W    = 8;
  localparam int         SWD  = 4;
  localparam logic [7:0] IDLE = 8'hBC;

  typedef struct {
    int         run;
    int         lo;
    int         hi;
    logic [1:0] v;
    logic [7:0] d0;
    logic [7:0] d1;
    logic       sr;
  } stim_t;

  typedef struct {
    int         run;
    int         k;
    logic [7:0] w0;
    logic [7:0] w1;
    logic       lu;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0]  v = '0;
  logic [15:0] d = '0;
  logic        sreq = 1'b0;

  logic       lu_a, ws_a, lu_b, ws_b;
  logic [1:0] so_a, so_b;

  int n_chk = 0;
  int n_fail = 0;

  // word-level reference state
  int         t;
  int         s;
  logic [7:0] mw [300][2];
  logic [7:0] ca [2];
  logic [7:0] cb [2];
  logic [7:0] wa [16][2];
  logic [7:0] wb [16][2];
  logic       luw [16];

  stim_t st [7];
  exp_t  ex [15];

  phy_tx_serializer_n_if #(.LANES(L), .WIDTH(W)) if_a ();
  phy_tx_serializer_n_if #(.LANES(L), .WIDTH(W)) if_b ();

  assign if_a.data_in  = d;
  assign if_a.valid_in = v;
  assign if_b.data_in  = d;
  assign if_b.valid_in = v;

  phy_tx_serializer_n #(
    .LANES(L), .WIDTH(W), .IDLE_WORD(IDLE),
    .SYNC_WORDS(SWD), .MSB_FIRST(1)
  ) dut_a (
    .clk_8f(clk), .reset(rst_n), .tx(if_a.slave),
    .sync_req(sreq), .link_up(lu_a),
    .word_strobe(ws_a), .serial_out(so_a)
  );

  phy_tx_serializer_n #(
    .LANES(L), .WIDTH(W), .IDLE_WORD(IDLE),
    .SYNC_WORDS(SWD), .MSB_FIRST(0)
  ) dut_b (
    .clk_8f(clk), .reset(rst_n), .tx(if_b.slave),
    .sync_req(sreq), .link_up(lu_b),
    .word_strobe(ws_b), .serial_out(so_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0d got %h expected %h", nm, t, act, exp);
    end
  endtask

  task automatic model_reset();
    t = 0;
    s = 0;
    mw[0][0] = IDLE;
    mw[0][1] = IDLE;
    for (int l = 0; l < 2; l++) begin
      ca[l] = '0;
      cb[l] = '0;
    end
    for (int k = 0; k < 16; k++) begin
      luw[k] = 1'b0;
      for (int l = 0; l < 2; l++) begin
        wa[k][l] = '0;
        wb[k][l] = '0;
      end
    end
  endtask

  task automatic do_reset();
    v = '0;
    d = '0;
    sreq = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_link_up", {lu_b, lu_a}, 2'b00);
    chk("rst_ready", {if_b.ready_out, if_a.ready_out}, 2'b00);
    chk("rst_strobe", {ws_b, ws_a}, 2'b00);
    chk("rst_ser_msb", so_a, 2'b11);
    chk("rst_ser_lsb", so_b, 2'b00);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic drive(input int r, input int tt);
    v = '0;
    d = '0;
    sreq = 1'b0;
    for (int i = 0; i < 7; i++) begin
      if (st[i].run == r && tt >= st[i].lo && tt <= st[i].hi) begin
        v = st[i].v;
        d = {st[i].d1, st[i].d0};
        sreq = st[i].sr;
      end
    end
  endtask

  // One serial cycle: check outputs mid-cycle against the model, then
  // decide the next word at a boundary and advance to the next cycle.
  task automatic cycle();
    int   k;
    int   b;
    logic lu;
    logic ws;
    logic rdy;
    @(negedge clk);
    k = t / W;
    b = t % W;
    lu = (k >= s + SWD);
    ws = (b == W - 1);
    rdy = lu && ws && !sreq;
    chk("link_up_msb", lu_a, lu);
    chk("link_up_lsb", lu_b, lu);
    chk("strobe_msb", ws_a, ws);
    chk("strobe_lsb", ws_b, ws);
    chk("ready_msb", if_a.ready_out, rdy);
    chk("ready_lsb", if_b.ready_out, rdy);
    for (int l = 0; l < 2; l++) begin
      chk("ser_msb", so_a[l], mw[k][l][W-1-b]);
      chk("ser_lsb", so_b[l], mw[k][l][b]);
      ca[l] = {ca[l][6:0], so_a[l]};
      cb[l][b] = so_b[l];
      if (ws && k < 16) begin
        wa[k][l] = ca[l];
        wb[k][l] = cb[l];
      end
    end
    if (b == 0 && k < 16) luw[k] = lu_a;
    if (ws) begin
      for (int l = 0; l < 2; l++) begin
        mw[k+1][l] = (rdy && v[l]) ? d[l*8 +: 8] : IDLE;
      end
      if (sreq) s = k + 1;
    end
    t++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int hold;

    st[0] = '{0, 39, 39, 2'b01, 8'hA4, 8'h32, 1'b0};
    st[1] = '{1, 39, 39, 2'b11, 8'hFF, 8'h00, 1'b0};
    st[2] = '{1, 47, 47, 2'b11, 8'hEE, 8'h01, 1'b0};
    st[3] = '{1, 55, 55, 2'b11, 8'hDD, 8'h02, 1'b0};
    st[4] = '{2, 40, 46, 2'b11, 8'h11, 8'h22, 1'b0};
    st[5] = '{3, 49, 53, 2'b00, 8'h00, 8'h00, 1'b1};
    st[6] = '{3, 55, 55, 2'b00, 8'h00, 8'h00, 1'b1};

    ex[0]  = '{0, 1,  8'hBC, 8'hBC, 1'b0};
    ex[1]  = '{0, 3,  8'hBC, 8'hBC, 1'b0};
    ex[2]  = '{0, 4,  8'hBC, 8'hBC, 1'b1};
    ex[3]  = '{0, 5,  8'hA4, 8'hBC, 1'b1};
    ex[4]  = '{0, 6,  8'hBC, 8'hBC, 1'b1};
    ex[5]  = '{1, 5,  8'hFF, 8'h00, 1'b1};
    ex[6]  = '{1, 6,  8'hEE, 8'h01, 1'b1};
    ex[7]  = '{1, 7,  8'hDD, 8'h02, 1'b1};
    ex[8]  = '{1, 8,  8'hBC, 8'hBC, 1'b1};
    ex[9]  = '{2, 5,  8'hBC, 8'hBC, 1'b1};
    ex[10] = '{2, 6,  8'hBC, 8'hBC, 1'b1};
    ex[11] = '{3, 6,  8'hBC, 8'hBC, 1'b1};
    ex[12] = '{3, 7,  8'hBC, 8'hBC, 1'b0};
    ex[13] = '{3, 10, 8'hBC, 8'hBC, 1'b0};
    ex[14] = '{3, 11, 8'hBC, 8'hBC, 1'b1};

    t = 0;
    // directed runs, each from a fresh reset
    for (int r = 0; r < 4; r++) begin
      do_reset();
      for (int c = 0; c < 104; c++) begin
        drive(r, t);
        cycle();
      end
      for (int i = 0; i < 15; i++) begin
        if (ex[i].run == r) begin
          chk($sformatf("word_msb r%0d k%0d", r, ex[i].k),
              {wa[ex[i].k][1], wa[ex[i].k][0]}, {ex[i].w1, ex[i].w0});
          chk($sformatf("word_lsb r%0d k%0d", r, ex[i].k),
              {wb[ex[i].k][1], wb[ex[i].k][0]}, {ex[i].w1, ex[i].w0});
          chk($sformatf("link_word r%0d k%0d", r, ex[i].k),
              luw[ex[i].k], ex[i].lu);
        end
      end
    end

    // reset asserted in the middle of the first data word
    do_reset();
    for (int c = 0; c < 43; c++) begin
      drive(0, t);
      cycle();
    end
    drive(-1, t);
    chk("pre_abort_link", {lu_b, lu_a}, 2'b11);
    chk("pre_abort_ser_msb", so_a[0], 1'b0);
    rst_n = 1'b0;
    #1;
    chk("abort_link", {lu_b, lu_a}, 2'b00);
    chk("abort_ready", {if_b.ready_out, if_a.ready_out}, 2'b00);
    chk("abort_strobe", {ws_b, ws_a}, 2'b00);
    chk("abort_ser_msb", so_a, 2'b11);
    chk("abort_ser_lsb", so_b, 2'b00);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    for (int c = 0; c < 48; c++) begin
      drive(-1, t);
      cycle();
    end

    // randomized traffic with occasional held retrain requests
    do_reset();
    hold = 0;
    for (int c = 0; c < 1600; c++) begin
      v = 2'($urandom);
      d = 16'($urandom);
      if ($urandom_range(7) == 0) d[7:0] = IDLE;
      if ($urandom_range(7) == 0) d[15:8] = IDLE;
      if (hold > 0) begin
        hold--;
      end else if ($urandom_range(99) < 2) begin
        hold = int'($urandom_range(12));
      end
      sreq = (hold > 0);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
